// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared defaults for the round-robin FIFO read controller.
// Contains the word width, the port count and the width of a port index.
package fifo_rr_arbiter_pkg;

    localparam int N_PORTS_DEF   = 4;
    localparam int DATA_W_DEF    = 10;
    localparam int CNT_W_DEF     = 16;
    localparam int PORT_ID_W_DEF = $clog2(N_PORTS_DEF);

    typedef logic [PORT_ID_W_DEF-1:0] port_id_t;
    typedef logic [DATA_W_DEF-1:0]    word_t;

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Upstream FIFO read bus and egress FIFO write bus seen by the arbiter.
// The master modport is the arbiter side; the slave modport is the FIFO side.
interface fifo_rr_arbiter_if
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int PORT_ID_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0]        fifo_empty;
    logic [N_PORTS*DATA_W-1:0] fifo_data;
    logic [N_PORTS-1:0]        fifo_rd_enb;
    logic                      out_almost_full;
    logic                      out_wr_enb;
    logic [DATA_W-1:0]         out_data;
    logic [PORT_ID_W-1:0]      grant_id;

    modport master (
        input  fifo_empty, fifo_data, out_almost_full,
        output fifo_rd_enb, out_wr_enb, out_data, grant_id
    );

    modport slave (
        output fifo_empty, fifo_data, out_almost_full,
        input  fifo_rd_enb, out_wr_enb, out_data, grant_id
    );

endinterface

// File: rtl/fifo_rr_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_PORTS.
module fifo_rr_arbiter_rr_select
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N_PORTS   = N_PORTS_DEF,
    parameter int PORT_ID_W = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0]   req,
    input  logic [PORT_ID_W-1:0] ptr,
    output logic [PORT_ID_W-1:0] gnt_id,
    output logic                 gnt_vld
);

    int idx_s;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx_s   = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx_s = (int'(ptr) + k) % N_PORTS;
            if (req[idx_s[PORT_ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx_s[PORT_ID_W-1:0];
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read controller: pops one word per cycle from non-empty upstream
// FIFOs and pushes it to the egress FIFO one cycle later.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fifo_rr_arbiter_if.master bus,
    output logic              idle,
    output logic [CNT_W-1:0]  word_count
);

    localparam int PORT_ID_W = $clog2(N_PORTS);

    logic [PORT_ID_W-1:0] rr_ptr_r;
    logic [PORT_ID_W-1:0] sel_r;
    logic                 inflight_r;
    logic [PORT_ID_W-1:0] gnt_id_s;
    logic                 gnt_vld_s;
    logic                 can_pop_s;
    logic                 wr_s;

    fifo_rr_arbiter_rr_select #(
        .N_PORTS   (N_PORTS),
        .PORT_ID_W (PORT_ID_W)
    ) u_rr_select (
        .req     (~bus.fifo_empty),
        .ptr     (rr_ptr_r),
        .gnt_id  (gnt_id_s),
        .gnt_vld (gnt_vld_s)
    );

    assign can_pop_s = enable & ~bus.out_almost_full & ~rst & gnt_vld_s;

    // A word still in flight when reset hits is dropped, not written.
    assign wr_s           = inflight_r & ~rst;
    assign bus.out_wr_enb = wr_s;
    assign idle           = rst | (~inflight_r & (&bus.fifo_empty));

    // One-hot pop strobe toward the granted FIFO.
    always_comb begin
        bus.fifo_rd_enb = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.fifo_rd_enb[i] = can_pop_s & (gnt_id_s == PORT_ID_W'(i));
        end
    end

    // Egress mux driven by the registered select; upstream data is already registered.
    always_comb begin
        bus.out_data = '0;
        bus.grant_id = '0;
        if (wr_s) begin
            bus.out_data = bus.fifo_data[sel_r*DATA_W +: DATA_W];
            bus.grant_id = sel_r;
        end else begin
            bus.out_data = '0;
            bus.grant_id = '0;
        end
    end

    // Pointer, in-flight tracking and forwarded-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= '0;
            sel_r      <= '0;
            inflight_r <= 1'b0;
            word_count <= '0;
        end else begin
            inflight_r <= can_pop_s;
            if (can_pop_s) begin
                sel_r    <= gnt_id_s;
                rr_ptr_r <= (gnt_id_s == PORT_ID_W'(N_PORTS - 1)) ? '0 : gnt_id_s + 1'b1;
            end else begin
                sel_r    <= sel_r;
                rr_ptr_r <= rr_ptr_r;
            end
            if (wr_s) begin
                word_count <= word_count + CNT_W'(1);
            end else begin
                word_count <= word_count;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a queue model of the upstream FIFOs
// (registered read: data appears the cycle after the pop strobe).
module tb_fifo_rr_arbiter;
    import fifo_rr_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int DW = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          idle;
    logic [CW-1:0] word_count;

    fifo_rr_arbiter_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();

    fifo_rr_arbiter #(.N_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .idle       (idle),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q [NP][$];
    logic [DW-1:0] t2_dat [NP][3];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < NP; i++) bus.fifo_empty[i] = (q[i].size() == 0);
    endtask

    task automatic load(input int p, input logic [DW-1:0] w);
        q[p].push_back(w);
        upd_empty();
    endtask

    // One clock: sample pop strobes, clock edge, model the registered FIFO read.
    task automatic cyc();
        logic [NP-1:0] rd;
        rd = bus.fifo_rd_enb;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd[i] && q[i].size() > 0) bus.fifo_data[i*DW +: DW] = q[i].pop_front();
        end
        upd_empty();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) q[i].delete();
        upd_empty();
        bus.fifo_data = '0;
        cyc();
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        bus.out_almost_full = 1'b0;
        bus.fifo_data = '0;
        for (int i = 0; i < NP; i++) q[i].delete();
        upd_empty();

        // 1: reset with every FIFO non-empty
        for (int p = 0; p < NP; p++) load(p, DW'(p + 1));
        cyc();
        cyc();
        chk("t1_rd_enb", 32'(bus.fifo_rd_enb), 32'h0);
        chk("t1_wr_enb", 32'(bus.out_wr_enb), 32'h0);
        chk("t1_count", 32'(word_count), 32'h0);
        chk("t1_idle", 32'(idle), 32'h1);
        chk("t1_out_data", 32'(bus.out_data), 32'h0);
        chk("t1_grant_id", 32'(bus.grant_id), 32'h0);

        // 2: fairness, 4 ports x 3 words
        do_reset();
        t2_dat[0] = '{10'd10, 10'd15, 10'd20};
        t2_dat[1] = '{10'd100, 10'd101, 10'd102};
        t2_dat[2] = '{10'd200, 10'd201, 10'd202};
        t2_dat[3] = '{10'd300, 10'd301, 10'd302};
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < 3; j++) load(p, t2_dat[p][j]);
        rst = 1'b0;
        #1;
        chk("t2_rd_first", 32'(bus.fifo_rd_enb), 32'h1);
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("t2_wr_enb", 32'(bus.out_wr_enb), 32'h1);
            chk("t2_out_data", 32'(bus.out_data), 32'(t2_dat[k % 4][k / 4]));
            chk("t2_grant_id", 32'(bus.grant_id), 32'(k % 4));
            chk("t2_count", 32'(word_count), 32'(k));
            chk("t2_rd_enb", 32'(bus.fifo_rd_enb), (k < 11) ? (32'h1 << ((k + 1) % 4)) : 32'h0);
        end
        cyc();
        chk("t2_wr_done", 32'(bus.out_wr_enb), 32'h0);
        chk("t2_count_end", 32'(word_count), 32'd12);
        chk("t2_idle", 32'(idle), 32'h1);

        // 3: skip empty ports, rr_ptr moved to 1 first
        do_reset();
        load(0, 10'd50);
        rst = 1'b0;
        #1;
        cyc();
        chk("t3_prime", 32'(bus.out_data), 32'd50);
        load(0, 10'd51);
        load(0, 10'd52);
        load(2, 10'd250);
        load(2, 10'd251);
        #1;
        chk("t3_rd_a", 32'(bus.fifo_rd_enb), 32'h4);
        cyc();
        chk("t3_gid_a", 32'(bus.grant_id), 32'd2);
        chk("t3_dat_a", 32'(bus.out_data), 32'd250);
        chk("t3_rd_b", 32'(bus.fifo_rd_enb), 32'h1);
        cyc();
        chk("t3_gid_b", 32'(bus.grant_id), 32'd0);
        chk("t3_dat_b", 32'(bus.out_data), 32'd51);
        chk("t3_rd_c", 32'(bus.fifo_rd_enb), 32'h4);
        cyc();
        chk("t3_gid_c", 32'(bus.grant_id), 32'd2);
        chk("t3_dat_c", 32'(bus.out_data), 32'd251);
        load(1, 10'd150);
        #1;
        chk("t3_rd_d", 32'(bus.fifo_rd_enb), 32'h1);
        cyc();
        chk("t3_gid_d", 32'(bus.grant_id), 32'd0);
        chk("t3_rd_e", 32'(bus.fifo_rd_enb), 32'h2);
        cyc();
        chk("t3_gid_e", 32'(bus.grant_id), 32'd1);
        chk("t3_dat_e", 32'(bus.out_data), 32'd150);
        chk("t3_rd_none", 32'(bus.fifo_rd_enb), 32'h0);
        cyc();
        chk("t3_wr_done", 32'(bus.out_wr_enb), 32'h0);
        chk("t3_idle", 32'(idle), 32'h1);

        // 4: backpressure in cycles 5..7, then enable drop
        do_reset();
        for (int p = 0; p < NP; p++) begin
            load(p, DW'(p * 16 + 1));
            load(p, DW'(p * 16 + 2));
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) cyc();
        bus.out_almost_full = 1'b1;
        #1;
        chk("t4_rd_c5", 32'(bus.fifo_rd_enb), 32'h0);
        chk("t4_wr_c5", 32'(bus.out_wr_enb), 32'h1);
        chk("t4_dat_c5", 32'(bus.out_data), 32'h002);
        chk("t4_gid_c5", 32'(bus.grant_id), 32'd0);
        cyc();
        chk("t4_rd_c6", 32'(bus.fifo_rd_enb), 32'h0);
        chk("t4_wr_c6", 32'(bus.out_wr_enb), 32'h0);
        cyc();
        chk("t4_rd_c7", 32'(bus.fifo_rd_enb), 32'h0);
        cyc();
        bus.out_almost_full = 1'b0;
        #1;
        chk("t4_rd_c8", 32'(bus.fifo_rd_enb), 32'h2);
        cyc();
        chk("t4_dat_c9", 32'(bus.out_data), 32'h012);
        chk("t4_gid_c9", 32'(bus.grant_id), 32'd1);
        chk("t4_rd_c9", 32'(bus.fifo_rd_enb), 32'h4);
        enable = 1'b0;
        #1;
        chk("t4_rd_noen", 32'(bus.fifo_rd_enb), 32'h0);
        chk("t4_wr_noen", 32'(bus.out_wr_enb), 32'h1);
        cyc();
        chk("t4_wr_c10", 32'(bus.out_wr_enb), 32'h0);
        enable = 1'b1;

        // 5: single word latency and data
        do_reset();
        load(2, 10'h2AA);
        rst = 1'b0;
        #1;
        chk("t5_rd_t", 32'(bus.fifo_rd_enb), 32'h4);
        chk("t5_wr_t", 32'(bus.out_wr_enb), 32'h0);
        cyc();
        chk("t5_wr_t1", 32'(bus.out_wr_enb), 32'h1);
        chk("t5_dat_t1", 32'(bus.out_data), 32'h2AA);
        chk("t5_gid_t1", 32'(bus.grant_id), 32'd2);
        chk("t5_rd_t1", 32'(bus.fifo_rd_enb), 32'h0);
        cyc();
        chk("t5_dat_t2", 32'(bus.out_data), 32'h0);
        chk("t5_idle", 32'(idle), 32'h1);

        // 6: reset while a word is in flight, then counter wrap
        do_reset();
        load(1, 10'h3F0);
        load(1, 10'h3F1);
        rst = 1'b0;
        #1;
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_wr_rst", 32'(bus.out_wr_enb), 32'h0);
        chk("t6_dat_rst", 32'(bus.out_data), 32'h0);
        chk("t6_rd_rst", 32'(bus.fifo_rd_enb), 32'h0);
        load(0, 10'h005);
        load(3, 10'h035);
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_wr_after", 32'(bus.out_wr_enb), 32'h0);
        chk("t6_ptr_zero", 32'(bus.fifo_rd_enb), 32'h1);

        do_reset();
        for (int k = 0; k < 17; k++) load(0, DW'(k + 16));
        rst = 1'b0;
        #1;
        for (int n = 1; n <= 18; n++) begin
            cyc();
            if (n <= 17) chk("t6_wrap_dat", 32'(bus.out_data), 32'(n + 15));
        end
        chk("t6_wrap_count", 32'(word_count), 32'd1);
        chk("t6_wrap_wr", 32'(bus.out_wr_enb), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
